// File: rtl/scm_bist_pkg.sv
// Shared types and the March C- element table for the SCM BIST controller.
package scm_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;

    typedef struct packed {
        logic we;
        logic d;
    } march_op_t;

    typedef struct packed {
        logic             down;
        logic             last;   // index of the final op in the element
        march_op_t [1:0]  op;
    } march_elem_t;

    localparam march_op_t OP_W0 = '{we: 1'b1, d: 1'b0};
    localparam march_op_t OP_W1 = '{we: 1'b1, d: 1'b1};
    localparam march_op_t OP_R0 = '{we: 1'b0, d: 1'b0};
    localparam march_op_t OP_R1 = '{we: 1'b0, d: 1'b1};

    function automatic march_elem_t elem_info(input march_elem_e e);
        march_elem_t t;
        t = '0;
        case (e)
            M0: begin t.down = 1'b0; t.last = 1'b0; t.op[0] = OP_W0; end
            M1: begin t.down = 1'b0; t.last = 1'b1; t.op[0] = OP_R0; t.op[1] = OP_W1; end
            M2: begin t.down = 1'b0; t.last = 1'b1; t.op[0] = OP_R1; t.op[1] = OP_W0; end
            M3: begin t.down = 1'b1; t.last = 1'b1; t.op[0] = OP_R0; t.op[1] = OP_W1; end
            M4: begin t.down = 1'b1; t.last = 1'b1; t.op[0] = OP_R1; t.op[1] = OP_W0; end
            M5: begin t.down = 1'b1; t.last = 1'b0; t.op[0] = OP_R0; end
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/scm_bist_cmp.sv
// Read-check pipe: delays issue-time {addr, expected} by READ_LATENCY and compares with Q_T.
module scm_bist_cmp #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  iss_valid_i,
    input  logic [ADDR_WIDTH-1:0] iss_addr_i,
    input  logic [DATA_WIDTH-1:0] iss_exp_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  miscmp_o,
    output logic [ADDR_WIDTH-1:0] miscmp_addr_o
);

    logic [READ_LATENCY-1:0] vld_q;
    logic [ADDR_WIDTH-1:0]   addr_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   exp_q  [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q[0]  <= iss_valid_i & ~flush_i;
            addr_q[0] <= iss_addr_i;
            exp_q[0]  <= iss_exp_i;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1] & ~flush_i;
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
            end
        end
    end

    assign miscmp_o      = vld_q[READ_LATENCY-1] && (q_i != exp_q[READ_LATENCY-1]);
    assign miscmp_addr_o = addr_q[READ_LATENCY-1];

endmodule

// File: rtl/scm_march_bist_ctrl.sv
// March C- BIST engine driving the SCM wrapper BIST port; one full-array test per start.
module scm_march_bist_ctrl
    import scm_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_BYTE     = DATA_WIDTH / 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    localparam int unsigned DRW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [DRW-1:0] DRAIN_LAST = DRW'(READ_LATENCY - 1);

    bist_state_e           state_q, state_d;
    march_elem_e           elem_q, elem_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DRW-1:0]        drain_q, drain_d;

    logic                  csn_q, csn_d, wen_q, wen_d, bist_q, bist_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [NUM_BYTE-1:0]   be_q, be_d;

    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;

    logic                  start_acc;
    logic                  miscmp;
    logic [ADDR_WIDTH-1:0] miscmp_addr;

    march_elem_t           cur, nxt;
    logic                  issue;
    march_op_t             iss_op;
    logic [ADDR_WIDTH-1:0] iss_addr;

    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        op_d     = op_q;
        addr_d   = addr_q;
        drain_d  = drain_q;
        issue    = 1'b0;
        iss_op   = '0;
        iss_addr = addr_q;
        cur      = elem_info(elem_q);
        nxt      = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_d  = RUN;
                    elem_d   = M0;
                    op_d     = 1'b0;
                    addr_d   = '0;
                    issue    = 1'b1;
                    iss_op   = OP_W0;
                    iss_addr = '0;
                end
            end
            RUN: begin
                // Counters describe the op currently on the bus; pick the one after it.
                if (op_q != cur.last) begin
                    op_d     = 1'b1;
                    issue    = 1'b1;
                    iss_op   = cur.op[1];
                    iss_addr = addr_q;
                end else if (cur.down ? (addr_q != '0) : (addr_q != ADDR_MAX)) begin
                    op_d     = 1'b0;
                    addr_d   = cur.down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    issue    = 1'b1;
                    iss_op   = cur.op[0];
                    iss_addr = addr_d;
                end else if (elem_q != M5) begin
                    elem_d   = march_elem_e'(elem_q + 3'd1);
                    nxt      = elem_info(elem_d);
                    op_d     = 1'b0;
                    addr_d   = nxt.down ? ADDR_MAX : '0;
                    issue    = 1'b1;
                    iss_op   = nxt.op[0];
                    iss_addr = addr_d;
                end else begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        csn_d  = ~issue;
        wen_d  = issue ? ~iss_op.we : 1'b1;
        a_d    = issue ? iss_addr : a_q;
        dat_d  = issue ? {DATA_WIDTH{iss_op.d}} : '0;
        be_d   = issue ? '1 : '0;
        bist_d = (state_d != IDLE);

        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
        if (start_acc) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_cnt_d  = '0;
        end else if (miscmp) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = miscmp_addr;
            end
            if (fail_cnt_q != '1) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_q      <= M0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            drain_q     <= '0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            dat_q       <= '0;
            be_q        <= '0;
            bist_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            dat_q       <= dat_d;
            be_q        <= be_d;
            bist_q      <= bist_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // D_T carries the background on reads too, so it doubles as the expected value.
    scm_bist_cmp #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_cmp (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (start_acc),
        .iss_valid_i  (~csn_q & wen_q),
        .iss_addr_i   (a_q),
        .iss_exp_i    (dat_q),
        .q_i          (Q_T),
        .miscmp_o     (miscmp),
        .miscmp_addr_o(miscmp_addr)
    );

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_count = fail_cnt_q;
    assign BIST       = bist_q;
    assign CSN_T      = csn_q;
    assign WEN_T      = wen_q;
    assign A_T        = a_q;
    assign D_T        = dat_q;
    assign BE_T       = be_q;

endmodule

// File: tb/tb_scm_march_bist_ctrl.sv
// Directed bench: behavioural SCM with injectable faults behind the BIST port.
module tb_scm_march_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, fail, BIST, CSN_T, WEN_T;
    logic [4:0]  fail_addr, A_T;
    logic [7:0]  fail_count;
    logic [31:0] D_T, Q_T;
    logic [3:0]  BE_T;

    int n_tests = 0;
    int n_fail  = 0;

    scm_march_bist_ctrl #(
        .ADDR_WIDTH  (5),
        .DATA_WIDTH  (32),
        .NUM_BYTE    (4),
        .READ_LATENCY(1),
        .CNT_WIDTH   (8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_count(fail_count), .BIST(BIST),
        .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .BE_T(BE_T), .Q_T(Q_T)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    logic [31:0] q_r = '0;
    bit sa_fault  = 0;
    bit dec_fault = 0;
    assign Q_T = q_r;

    always @(posedge clk) begin
        if (!CSN_T) begin
            if (!WEN_T) begin
                mem[A_T] <= D_T;
                if (dec_fault && A_T == 5'd4) mem[5] <= D_T;
            end else begin
                q_r <= mem[A_T];
                if (sa_fault && A_T == 5'd7) q_r[0] <= 1'b1;
            end
        end
    end

    logic [4:0]  log_a   [400];
    logic        log_wen [400];
    logic [31:0] log_d   [400];
    int ops, be_bad, done_cyc;
    logic f0_fail, f0_done, f0_busy;
    logic [7:0] f0_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the one following the edge that samples start.
    task automatic run_march(input int pulse_at);
        int cyc;
        bit seen;
        ops = 0; be_bad = 0; seen = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); cyc = 0; #1;
        f0_fail = fail; f0_cnt = fail_count; f0_done = done; f0_busy = busy;
        while (!seen && cyc < 2000) begin
            start = (cyc == pulse_at);
            if (CSN_T == 1'b0) begin
                if (ops < 400) begin
                    log_a[ops] = A_T; log_wen[ops] = WEN_T; log_d[ops] = D_T;
                end
                ops++;
                if (BE_T !== 4'hF) be_bad++;
            end
            if (done) seen = 1;
            else begin
                @(posedge clk); cyc++; #1;
            end
        end
        start = 1'b0;
        done_cyc = seen ? cyc + 1 : -1;
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        #12;
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);       chk("rst_bist", BIST, 0);
        chk("rst_faddr", fail_addr, 0); chk("rst_fcnt", fail_count, 0);
        chk("rst_csn", CSN_T, 1);       chk("rst_wen", WEN_T, 1);
        chk("rst_a", A_T, 0);           chk("rst_d", D_T, 0);
        chk("rst_be", BE_T, 0);
        @(negedge clk); rst_n = 1'b1;

        // Fault-free run plus protocol trace
        run_march(-1);
        chk("t1_done_cyc", done_cyc, 322);
        chk("t1_fail", fail, 0);
        chk("t1_fcnt", fail_count, 0);
        chk("t1_ops", ops, 320);
        chk("t1_be_all_ops", be_bad, 0);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_bist_at_done", BIST, 1);
        chk("t1_csn_at_done", CSN_T, 1);
        chk("t1_be_at_done", BE_T, 0);
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (log_a[i] !== 5'(i) || log_wen[i] !== 1'b0 || log_d[i] !== 32'h0) bad++;
        chk("t4_m0_writes", bad, 0);
        chk("t4_m1_first_a", log_a[32], 0);   chk("t4_m1_first_wen", log_wen[32], 1);
        chk("t4_m1_w1_d", log_d[33], 32'hFFFF_FFFF); chk("t4_m1_w1_wen", log_wen[33], 0);
        chk("t4_m3_first_a", log_a[160], 31); chk("t4_m3_first_wen", log_wen[160], 1);
        chk("t4_m3_first_d", log_d[160], 0);
        chk("t4_last_a", log_a[319], 0);      chk("t4_last_wen", log_wen[319], 1);
        repeat (3) @(posedge clk);
        #1 chk("t1_done_held", done, 1);

        // Stuck-at-1 on bit 0 of address 7, started from DONE
        sa_fault = 1;
        run_march(-1);
        sa_fault = 0;
        chk("t2_done_cyc", done_cyc, 322);
        chk("t2_fail", fail, 1);
        chk("t2_faddr", fail_addr, 7);
        chk("t2_fcnt", fail_count, 3);

        // Decoder fault from DONE: previous results must clear on the accepted start
        dec_fault = 1;
        run_march(-1);
        dec_fault = 0;
        chk("t6_clr_fail", f0_fail, 0);
        chk("t6_clr_fcnt", f0_cnt, 0);
        chk("t6_done_drop", f0_done, 0);
        chk("t6_busy_rise", f0_busy, 1);
        chk("t3_fail", fail, 1);
        chk("t3_faddr", fail_addr, 5);
        chk("t3_fcnt_nonzero", fail_count != 0, 1);

        // start pulsed mid-run is ignored
        run_march(5);
        chk("t6_done_cyc", done_cyc, 322);
        chk("t6_fail", fail, 0);
        chk("t6_ops", ops, 320);

        // Reset in cycle 100 of a run
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (99) @(posedge clk);
        #1 chk("t5_pre_csn_active", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_csn", CSN_T, 1);
        chk("t5_bist", BIST, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        run_march(-1);
        chk("t5_done_cyc", done_cyc, 322);
        chk("t5_fail", fail, 0);
        chk("t5_fcnt", fail_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
